// File: rtl/apb_rr_master_if.sv
// APB bus bundle between the round-robin master and a single slave.
interface apb_rr_master_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_rr_master.sv
// APB master shared by N_REQ requesters through a round-robin arbiter,
// with a per-transfer PREADY timeout.
module apb_rr_master #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_write,
    input  logic [32*N_REQ-1:0]  req_addr,
    input  logic [32*N_REQ-1:0]  req_wdata,
    input  logic [4*N_REQ-1:0]   req_strb,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    apb_rr_master_if.master      apb
);
    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   last_grant_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   cand;
    logic            grant_found;
    logic [CW-1:0]   wait_q;
    logic            timeout_hit;
    logic [31:0]     paddr_q;
    logic [31:0]     pwdata_q;
    logic [3:0]      pstrb_q;
    logic            pwrite_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    // Search starts one past the last grant so every requester is served in turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = GW'((int'(last_grant_q) + i) % int'(N_REQ));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign timeout_hit = (wait_q == CW'(TIMEOUT - 1)) && !apb.PREADY;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d              = StSetup;
                    req_ready[grant_idx] = 1'b1;
                end
            end
            StSetup:  state_d = StAccess;
            StAccess: if (apb.PREADY || timeout_hit) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant_q <= GW'(N_REQ - 1);
            grant_q      <= '0;
            wait_q       <= '0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            pwrite_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        last_grant_q <= grant_idx;
                        grant_q      <= grant_idx;
                        paddr_q      <= req_addr[32*grant_idx +: 32];
                        pwdata_q     <= req_wdata[32*grant_idx +: 32];
                        pwrite_q     <= req_write[grant_idx];
                        // Reads never carry byte strobes on the bus.
                        pstrb_q      <= req_write[grant_idx] ? req_strb[4*grant_idx +: 4] : 4'b0000;
                    end
                end
                StSetup: wait_q <= '0;
                StAccess: begin
                    if (apb.PREADY) begin
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_err_q            <= apb.PSLVERR;
                        rsp_rdata_q          <= pwrite_q ? 32'h0 : apb.PRDATA;
                    end else if (timeout_hit) begin
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_err_q            <= 1'b1;
                        rsp_rdata_q          <= 32'h0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign apb.PSEL    = (state_q != StIdle);
    assign apb.PENABLE = (state_q == StAccess);
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;
    assign apb.PPROT   = 3'b000;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle);
endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: two requesters, a small memory slave
// with programmable wait states, error response and hang.
module tb_apb_rr_master;
    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req_valid, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_rr_master_if apb_bus();

    apb_rr_master #(.N_REQ(2), .TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .apb       (apb_bus.master)
    );

    // Slave model
    logic [31:0] mem [16];
    int          wcnt = 0;
    bit          slv_hang = 1'b0;
    bit          slv_err = 1'b0;
    int          slv_wait = 0;

    assign apb_bus.PREADY  = apb_bus.PSEL && apb_bus.PENABLE && !slv_hang && (wcnt >= slv_wait);
    assign apb_bus.PSLVERR = apb_bus.PREADY && slv_err;
    assign apb_bus.PRDATA  = mem[apb_bus.PADDR[5:2]];

    always @(posedge PCLK) begin
        if (apb_bus.PSEL && apb_bus.PENABLE && !apb_bus.PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (apb_bus.PSEL && apb_bus.PENABLE && apb_bus.PREADY && apb_bus.PWRITE)
            for (int b = 0; b < 4; b++)
                if (apb_bus.PSTRB[b]) mem[apb_bus.PADDR[5:2]][8*b +: 8] <= apb_bus.PWDATA[8*b +: 8];
    end

    task automatic set_req(input int p, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        req_valid[p]           = 1'b1;
        req_write[p]           = wr;
        req_addr[32*p +: 32]   = addr;
        req_wdata[32*p +: 32]  = wdata;
        req_strb[4*p +: 4]     = strb;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        repeat (2) @(negedge PCLK);
        checks++; if (apb_bus.PSEL !== 1'b0) begin errors++; $display("FAIL rst_psel got %b exp 0", apb_bus.PSEL); end
        checks++; if (apb_bus.PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", apb_bus.PENABLE); end
        checks++; if (apb_bus.PWRITE !== 1'b0) begin errors++; $display("FAIL rst_pwrite got %b exp 0", apb_bus.PWRITE); end
        checks++; if (apb_bus.PADDR !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h exp 0", apb_bus.PADDR); end
        checks++; if (apb_bus.PWDATA !== 32'h0) begin errors++; $display("FAIL rst_pwdata got %h exp 0", apb_bus.PWDATA); end
        checks++; if (apb_bus.PSTRB !== 4'h0) begin errors++; $display("FAIL rst_pstrb got %h exp 0", apb_bus.PSTRB); end
        checks++; if (apb_bus.PPROT !== 3'b000) begin errors++; $display("FAIL rst_pprot got %b exp 000", apb_bus.PPROT); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
        PRESETn = 1'b1;
    endtask

    // Accept issued on the very first edge after reset release.
    task automatic test_write();
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready got %b exp 01", req_ready); end
        @(negedge PCLK);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL wr_ready_setup got %b exp 00", req_ready); end
        checks++; if ({apb_bus.PSEL, apb_bus.PENABLE} !== 2'b10) begin errors++; $display("FAIL wr_setup_ctl got %b exp 10", {apb_bus.PSEL, apb_bus.PENABLE}); end
        checks++; if (apb_bus.PADDR !== 32'h10) begin errors++; $display("FAIL wr_setup_paddr got %h exp 10", apb_bus.PADDR); end
        checks++; if (apb_bus.PWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_setup_pwdata got %h exp deadbeef", apb_bus.PWDATA); end
        checks++; if ({apb_bus.PWRITE, apb_bus.PSTRB} !== 5'b11111) begin errors++; $display("FAIL wr_setup_wr_strb got %b exp 11111", {apb_bus.PWRITE, apb_bus.PSTRB}); end
        req_valid = '0;
        @(negedge PCLK);
        checks++; if ({apb_bus.PSEL, apb_bus.PENABLE} !== 2'b11) begin errors++; $display("FAIL wr_access_ctl got %b exp 11", {apb_bus.PSEL, apb_bus.PENABLE}); end
        checks++; if (apb_bus.PADDR !== 32'h10) begin errors++; $display("FAIL wr_access_paddr got %h exp 10", apb_bus.PADDR); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_early_rsp got %b exp 00", rsp_valid); end
        @(negedge PCLK);
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_rsp_valid got %b exp 01", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_err got %b exp 0", rsp_err); end
        checks++; if ({apb_bus.PSEL, busy} !== 2'b00) begin errors++; $display("FAIL wr_idle got %b exp 00", {apb_bus.PSEL, busy}); end
    endtask

    task automatic test_read();
        set_req(1, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_ready got %b exp 10", req_ready); end
        @(negedge PCLK);
        checks++; if (apb_bus.PSTRB !== 4'h0) begin errors++; $display("FAIL rd_pstrb got %h exp 0", apb_bus.PSTRB); end
        checks++; if (apb_bus.PWRITE !== 1'b0) begin errors++; $display("FAIL rd_pwrite got %b exp 0", apb_bus.PWRITE); end
        req_valid = '0;
        repeat (2) @(negedge PCLK);
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rd_rsp_valid got %b exp 10", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_err got %b exp 0", rsp_err); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        set_req(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        set_req(1, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", k, req_ready, exp); end
            repeat (2) @(negedge PCLK);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d got %b exp 1", k, busy); end
            @(negedge PCLK);
            checks++; if (rsp_valid !== exp) begin errors++; $display("FAIL b2b_rsp%0d got %b exp %b", k, rsp_valid, exp); end
            if (k % 2 == 1) begin
                checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata%0d got %h exp deadbeef", k, rsp_rdata); end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int  acc = 0;
        bit  done = 1'b0;
        slv_hang = 1'b1;
        set_req(0, 1'b0, 32'h30, 32'h0, 4'hF);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL to_ready got %b exp 01", req_ready); end
        @(negedge PCLK);
        req_valid = '0;
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_rdata_hold got %h exp deadbeef", rsp_rdata); end
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge PCLK);
            if (rsp_valid !== 2'b00) done = 1'b1;
            else if (apb_bus.PSEL && apb_bus.PENABLE) acc++;
        end
        checks++; if (!done) begin errors++; $display("FAIL to_bound got no rsp exp rsp within 40 cycles"); end
        checks++; if (acc != 16) begin errors++; $display("FAIL to_access_cycles got %0d exp 16", acc); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL to_rsp_valid got %b exp 01", rsp_valid); end
        checks++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_rsp got err %b rdata %h exp 1 0", rsp_err, rsp_rdata); end
        checks++; if (apb_bus.PSEL !== 1'b0) begin errors++; $display("FAIL to_psel got %b exp 0", apb_bus.PSEL); end
        @(negedge PCLK);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL to_pulse got %b exp 00", rsp_valid); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_err_hold got %b exp 1", rsp_err); end
        slv_hang = 1'b0;
    endtask

    task automatic test_slverr();
        int acc = 0;
        bit done = 1'b0;
        slv_wait = 3;
        slv_err  = 1'b1;
        set_req(1, 1'b1, 32'h44, 32'hCAFEF00D, 4'h3);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL se_ready got %b exp 10", req_ready); end
        @(negedge PCLK);
        req_valid = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge PCLK);
            if (rsp_valid !== 2'b00) begin
                done = 1'b1;
            end else begin
                acc++;
                checks++; if (apb_bus.PADDR !== 32'h44 || apb_bus.PWDATA !== 32'hCAFEF00D) begin
                    errors++; $display("FAIL se_stable got %h/%h exp 44/cafef00d", apb_bus.PADDR, apb_bus.PWDATA);
                end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL se_bound got no rsp exp rsp within 20 cycles"); end
        checks++; if (acc != 4) begin errors++; $display("FAIL se_access_cycles got %0d exp 4", acc); end
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL se_rsp_valid got %b exp 10", rsp_valid); end
        checks++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL se_rsp got err %b rdata %h exp 1 0", rsp_err, rsp_rdata); end
        slv_wait = 0;
        slv_err  = 1'b0;
    endtask

    task automatic test_reset_mid();
        slv_hang = 1'b1;
        set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rm_ready got %b exp 10", req_ready); end
        @(negedge PCLK);
        req_valid = '0;
        @(negedge PCLK);
        checks++; if (apb_bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rm_in_access got %b exp 1", apb_bus.PENABLE); end
        PRESETn = 1'b0;
        #1;
        checks++; if ({apb_bus.PSEL, apb_bus.PENABLE, busy} !== 3'b000) begin
            errors++; $display("FAIL rm_async got %b exp 000", {apb_bus.PSEL, apb_bus.PENABLE, busy});
        end
        checks++; if ({rsp_valid, rsp_rdata} !== 34'h0) begin errors++; $display("FAIL rm_rsp_clr got %b %h exp 0", rsp_valid, rsp_rdata); end
        slv_hang = 1'b0;
        set_req(0, 1'b1, 32'h50, 32'h0BADF00D, 4'hF);
        set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant got %b exp 01", req_ready); end
        @(negedge PCLK);
        req_valid = '0;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_no_rsp1 got %b exp 00", rsp_valid); end
        @(negedge PCLK);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_no_rsp2 got %b exp 00", rsp_valid); end
        @(negedge PCLK);
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rm_new_rsp got %b exp 01", rsp_valid); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        @(negedge PCLK);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_slverr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
